fs_prefetch_queue: RTL and testbench
====================================

// Module: fs_prefetch_queue
// PURPOSE
// - Next-generation IF stage: decoupled fetch with up to MAX_OUTST outstanding inst_sram requests.
// - QDEPTH-entry instruction queue between the inst_sram data return and ID.
// - Redirects (branch/exception/ertn/refetch) flush the queue and silently drop stale in-flight responses.
// - Sits between the PC source / redirect logic and ds; replaces the single-entry inst buffer.
// PARAMETERS
// - QDEPTH      4             instruction queue entries, power of 2, >=2
// - MAX_OUTST   2             max accepted-but-unreturned inst_sram requests, 1..QDEPTH
// - RESET_PC    32'h1c000000  first fetch address after reset
// PORTS
// - clk               in   1   clock
// - resetn            in   1   synchronous, active-low reset
// - redirect_valid    in   1   flush and restart fetch at redirect_pc
// - redirect_pc       in   32  new fetch PC
// - fetch_stall       in   1   hold new requests (br_stall); in-flight requests still complete
// - inst_sram_req     out  1   request valid
// - inst_sram_addr    out  32  fetch address (physical == virtual in this block)
// - inst_sram_size    out  2   constant 2'b10
// - inst_sram_addr_ok in   1   request accepted
// - inst_sram_data_ok in   1   in-order data return
// - inst_sram_rdata   in   32  returned instruction
// - ds_allowin        in   1   ds can accept
// - fs_to_ds_valid    out  1   queue head valid
// - fs_to_ds_bus      out  65  {ex_adef, inst[31:0], pc[31:0]}
// BEHAVIOUR
// - Reset (resetn==0 at posedge): fetch_pc<=RESET_PC; queue, PC-tag FIFO, outstanding, discard counters <=0;
//   halted<=0. Outputs during/after reset: inst_sram_req=0, fs_to_ds_valid=0 until the first data return.
// - Counters: outst, qcount, discard, each $clog2(QDEPTH+1) bits; never wrap.
// - Credit: inst_sram_req = ~redirect_valid & ~fetch_stall & ~halted & fetch_pc[1:0]==0
//   & outst<MAX_OUTST & (qcount+outst)<QDEPTH. Guarantees a queue push never hits full.
// - req/addr stable while req=1 and addr_ok=0 unless redirect_valid (then req drops, allowed).
// - Accept (req&addr_ok): push fetch_pc into PC-tag FIFO (depth MAX_OUTST); fetch_pc<=fetch_pc+4; outst++.
// - Return (data_ok): pop PC-tag; outst--. If discard!=0: discard--, drop. Else push {0,rdata,tag} to queue.
// - Dequeue: fs_to_ds_valid & ds_allowin pops head. Push and pop same cycle: qcount unchanged.
// - Latency: data_ok at cycle N -> fs_to_ds_valid at N+1 (see CONFIGURATION for bypass).
// - Redirect (highest priority): queue cleared; fetch_pc<=redirect_pc; halted<=0;
//   discard<=outst - data_ok (responses returning in the redirect cycle are themselves dropped);
//   any data_ok in the redirect cycle is dropped; no accept can occur (req=0).
// - ADEF: fetch_pc[1:0]!=0 -> no request; once outst==0 and qcount<QDEPTH push {1,32'h0,fetch_pc}
//   (inst field = 32'h0; ds decodes ex) and set halted. Fetch stays halted until redirect.
//   Ordering with older instructions preserved by waiting for outst==0.
// - fetch_pc+4 wraps modulo 2^32 with no special handling.
// - Reset asserted mid-transaction: all state cleared; late data_ok after reset ignored (outst==0 -> no pop).
// - Protocol violation data_ok with outst==0: ignored, no counter underflow (assertion in bench).
// CONFIGURATION
// - FS_QUEUE_BYPASS_EN defined: when qcount==0 and an undropped data_ok arrives, the entry is presented
//   combinationally the same cycle (fs_to_ds_valid=1); if ds_allowin it is consumed and not pushed.
//   Latency data_ok->ds = 0 cycles.
// - Undefined: every return goes through the queue; latency 1 cycle; no rdata->ds combinational path.
// TESTING
// - Reset release, addr_ok=1 every cycle, data_ok 1 cycle later, ds_allowin=1 -> pcs 1c000000,1c000004,
//   1c000008 delivered in order, one per cycle steady state.
// - ds_allowin=0 for 10 cycles, memory always ready -> exactly QDEPTH accepted requests total,
//   queue fills to 4, req=0 thereafter; on release the 4 entries drain in PC order.
// - 2 requests outstanding (1c000000,1c000004), redirect to 1c000100 -> both returns dropped,
//   discard 2->0, next delivered pc=1c000100.
// - Redirect in same cycle as data_ok with outst=2 -> discard=1; next return dropped; following one delivered.
// - redirect_pc=1c000102 -> no inst_sram_req; one entry {ex_adef=1,pc=1c000102}; then idle until redirect.
// - FS_QUEUE_BYPASS_EN set vs unset, empty queue, data_ok at cycle N -> fs_to_ds_valid at N vs N+1.

Source files
------------

// File: rtl/fs_prefetch_queue.sv
// Decoupled IF stage: up to MAX_OUTST in-flight inst_sram requests feeding a QDEPTH-entry queue to ds.
// Define FS_QUEUE_BYPASS_EN to present an undropped return to ds in the same cycle when the queue is empty.
module fs_prefetch_queue #(
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_stall,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    output logic [1:0]  inst_sram_size,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned QW = $clog2(QDEPTH);
    localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [31:0]   fetch_pc;
    logic          halted;
    logic [CW-1:0] outst;
    logic [CW-1:0] qcount;
    logic [CW-1:0] discard;

    logic [64:0]   queue [QDEPTH];
    logic [QW-1:0] q_head;
    logic [QW-1:0] q_tail;

    logic [31:0]   tag_fifo [MAX_OUTST];
    logic [TW-1:0] tag_rd;
    logic [TW-1:0] tag_wr;

    logic          ret;
    logic          drop;
    logic          deliver;
    logic          accept;
    logic          adef_push;
    logic          bypass_take;
    logic          q_push;
    logic          q_pop;
    logic [CW:0]   inflight;
    logic [64:0]   ret_entry;
    logic [64:0]   push_entry;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
    endfunction

    // A data_ok with nothing outstanding is a protocol violation and is ignored.
    assign ret       = resetn & inst_sram_data_ok & (outst != '0);
    assign drop      = redirect_valid | (discard != '0);
    assign deliver   = ret & ~drop;
    assign ret_entry = {1'b0, inst_sram_rdata, tag_fifo[tag_rd]};

    // Credit counts queued plus in-flight entries so a push can never find the queue full.
    assign inflight       = {1'b0, qcount} + {1'b0, outst};
    assign inst_sram_req  = resetn & ~redirect_valid & ~fetch_stall & ~halted
                          & (fetch_pc[1:0] == 2'b00)
                          & (outst < CW'(MAX_OUTST))
                          & (inflight < (CW + 1)'(QDEPTH));
    assign inst_sram_addr = fetch_pc;
    assign inst_sram_size = 2'b10;
    assign accept         = inst_sram_req & inst_sram_addr_ok;

    // Waiting for outst==0 keeps the ADEF entry behind every older instruction.
    assign adef_push = resetn & ~redirect_valid & ~halted & (fetch_pc[1:0] != 2'b00)
                     & (outst == '0) & (qcount < CW'(QDEPTH));

`ifdef FS_QUEUE_BYPASS_EN
    logic bypass_valid;
    assign bypass_valid   = deliver & (qcount == '0);
    assign fs_to_ds_valid = resetn & ((qcount != '0) | bypass_valid);
    assign fs_to_ds_bus   = (qcount == '0) ? ret_entry : queue[q_head];
    assign bypass_take    = bypass_valid & ds_allowin;
`else
    assign fs_to_ds_valid = resetn & (qcount != '0);
    assign fs_to_ds_bus   = queue[q_head];
    assign bypass_take    = 1'b0;
`endif

    assign q_pop      = (qcount != '0) & ds_allowin;
    assign q_push     = (deliver & ~bypass_take) | adef_push;
    assign push_entry = adef_push ? {1'b1, 32'h0, fetch_pc} : ret_entry;

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_fifo[tag_wr] <= fetch_pc;
        end
        if (q_push & ~redirect_valid) begin
            queue[q_tail] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
            outst    <= '0;
            qcount   <= '0;
            discard  <= '0;
            q_head   <= '0;
            q_tail   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else begin
            // Tags track every accepted request, including ones later discarded.
            if (accept) begin
                tag_wr <= tag_next(tag_wr);
            end
            if (ret) begin
                tag_rd <= tag_next(tag_rd);
            end
            outst <= outst + CW'(accept) - CW'(ret);

            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                halted   <= 1'b0;
                discard  <= outst - CW'(ret);
                qcount   <= '0;
                q_head   <= '0;
                q_tail   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (adef_push) begin
                    halted <= 1'b1;
                end
                if (ret && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (q_push) begin
                    q_tail <= q_tail + QW'(1);
                end
                if (q_pop) begin
                    q_head <= q_head + QW'(1);
                end
                qcount <= qcount + CW'(q_push) - CW'(q_pop);
            end
        end
    end

endmodule

// File: tb/tb_fs_prefetch_queue.sv
// Directed bench for fs_prefetch_queue: in-order in-memory model with 1-cycle response latency.
module tb_fs_prefetch_queue;

    localparam logic [31:0] RST_PC = 32'h1c000000;
`ifdef FS_QUEUE_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_stall;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic [1:0]  inst_sram_size;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;

    fs_prefetch_queue dut (
        .clk               (clk),
        .resetn            (resetn),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fetch_stall       (fetch_stall),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_count = 0;
    int          c0;
    bit          resp_en;
    logic [31:0] pending [$];
    logic [64:0] dlog [$];
    int          dcyc [$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic logic [64:0] entry(input logic [31:0] pc);
        return {1'b0, mem_data(pc), pc};
    endfunction

    task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_drive();
        inst_sram_data_ok = resp_en && (pending.size() > 0);
        inst_sram_rdata   = inst_sram_data_ok ? mem_data(pending[0]) : 32'h0;
    endtask

    // Samples the closing cycle, advances one clock, then drives the new cycle's memory response.
    task automatic tick();
        logic        acc;
        logic        ret;
        logic [31:0] a;
        acc = inst_sram_req & inst_sram_addr_ok;
        a   = inst_sram_addr;
        ret = inst_sram_data_ok;
        if (fs_to_ds_valid === 1'b1 && ds_allowin) begin
            dlog.push_back(fs_to_ds_bus);
            dcyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ret && pending.size() > 0) void'(pending.pop_front());
        if (acc) begin
            pending.push_back(a);
            acc_count++;
        end
        mem_drive();
        #1;
    endtask

    task automatic do_reset();
        resetn            = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        fetch_stall       = 1'b0;
        inst_sram_addr_ok = 1'b0;
        ds_allowin        = 1'b0;
        resp_en           = 1'b0;
        pending.delete();
        mem_drive();
        repeat (2) tick();
        dlog.delete();
        dcyc.delete();
        acc_count = 0;
    endtask

    task automatic start(input bit aok, input bit ren, input bit allow);
        resetn            = 1'b1;
        inst_sram_addr_ok = aok;
        resp_en           = ren;
        ds_allowin        = allow;
        mem_drive();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state and steady-state streaming
        do_reset();
        check_eq("rst_req", inst_sram_req, 1'b0);
        check_eq("rst_valid", fs_to_ds_valid, 1'b0);
        check_eq("size", inst_sram_size, 2'b10);
        start(1'b1, 1'b1, 1'b1);
        c0 = cyc;
        check_eq("t1_req", inst_sram_req, 1'b1);
        check_eq("t1_addr", inst_sram_addr, RST_PC);
        tick();
        check_eq("t1_dok_valid", fs_to_ds_valid, (LAT == 0));
        repeat (6) tick();
        check_eq("t1_count", dlog.size() >= 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t1_pc%0d", i), dlog[i], entry(RST_PC + 32'(4 * i)));
        end
        check_eq("t1_latency", dcyc[0] - c0, 1 + LAT);
        check_eq("t1_rate", dcyc[2] - dcyc[0], 2);

        // Backpressure: exactly QDEPTH accepts, then in-order drain
        do_reset();
        start(1'b1, 1'b1, 1'b0);
        repeat (10) tick();
        check_eq("t2_accepts", acc_count, 4);
        check_eq("t2_req_off", inst_sram_req, 1'b0);
        check_eq("t2_valid", fs_to_ds_valid, 1'b1);
        check_eq("t2_head", fs_to_ds_bus, entry(RST_PC));
        ds_allowin = 1'b1;
        #1;
        repeat (4) tick();
        check_eq("t2_drained", dlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_pc%0d", i), dlog[i], entry(RST_PC + 32'(4 * i)));
        end

        // Redirect with two responses outstanding
        do_reset();
        start(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        check_eq("t3_req_credit", inst_sram_req, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c000100;
        #1;
        check_eq("t3_req_redir", inst_sram_req, 1'b0);
        tick();
        redirect_valid = 1'b0;
        resp_en        = 1'b1;
        mem_drive();
        #1;
        repeat (8) tick();
        check_eq("t3_first", dlog[0], entry(32'h1c000100));
        check_eq("t3_second", dlog[1], entry(32'h1c000104));

        // Redirect coinciding with a data return: only one more return is dropped
        do_reset();
        start(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        resp_en        = 1'b1;
        mem_drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c000200;
        #1;
        check_eq("t4_redir_valid", fs_to_ds_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        repeat (8) tick();
        check_eq("t4_first", dlog[0], entry(32'h1c000200));
        check_eq("t4_second", dlog[1], entry(32'h1c000204));

        // Misaligned redirect: single ADEF entry, then halted until the next redirect
        do_reset();
        start(1'b1, 1'b1, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c000102;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("t5_req", inst_sram_req, 1'b0);
        tick();
        check_eq("t5_valid", fs_to_ds_valid, 1'b1);
        check_eq("t5_entry", fs_to_ds_bus, {1'b1, 32'h0, 32'h1c000102});
        ds_allowin = 1'b1;
        #1;
        repeat (6) tick();
        check_eq("t5_count", dlog.size(), 1);
        check_eq("t5_accepts", acc_count, 0);
        check_eq("t5_halt_req", inst_sram_req, 1'b0);
        check_eq("t5_halt_valid", fs_to_ds_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c000300;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("t5_resume_req", inst_sram_req, 1'b1);
        check_eq("t5_resume_addr", inst_sram_addr, 32'h1c000300);

        // Stray data_ok with nothing outstanding must not underflow or push
        do_reset();
        fetch_stall = 1'b1;
        start(1'b1, 1'b0, 1'b1);
        check_eq("t6_stall_req", inst_sram_req, 1'b0);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'hbad0bad0;
        #1;
        tick();
        check_eq("t6_no_push", fs_to_ds_valid, 1'b0);
        fetch_stall = 1'b0;
        #1;
        check_eq("t6_req", inst_sram_req, 1'b1);
        check_eq("t6_addr", inst_sram_addr, RST_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
